// File: rtl/ddr2_rd_user_fifo_pkg.sv
// rtl/ddr2_rd_user_fifo_pkg.sv - shared DDR2 read user FIFO parameters and helpers
package ddr2_rd_user_fifo_pkg;

  localparam int DDR2_DATA_WIDTH      = 32;
  localparam int DDR2_BURST_LENGTH    = 4;
  localparam int DDR2_BURST_BEATS     = DDR2_BURST_LENGTH / 2;
  localparam int DDR2_USER_FIFO_DEPTH = 16;

  // True when one more burst still fits after stored and promised words.
  function automatic logic burst_fits(input int count, input int reserved,
                                      input int depth, input int beats);
    return (depth - count - reserved) >= beats;
  endfunction

endpackage

// File: rtl/ddr2_sync_fwft_fifo.sv
// rtl/ddr2_sync_fwft_fifo.sv - single-clock first-word-fall-through FIFO with registered output
module ddr2_sync_fwft_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic [CW-1:0]    o_count_nxt,
  output logic             o_push_ok,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;

  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic             w_bypass;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_left;
  logic [CW-1:0]    w_count_nxt;

  assign w_pop        = i_pop && (r_count != '0);
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_push_ok    = i_push && (!w_full || w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  assign w_count_left = r_count - CW'(w_pop);
  // A push landing where the next head will be must bypass the array.
  assign w_bypass     = w_push_ok && (w_count_left == '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push_ok && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_bypass)   r_dout <= i_wdata;
      else if (w_pop) r_dout <= r_mem[w_rd_ptr_nxt];
    end
  end

  assign o_valid     = (r_count != '0);
  assign o_rdata     = r_dout;
  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;
  assign o_push_ok   = w_push_ok;
  assign o_overflow  = i_push && w_full && !w_pop;

endmodule

// File: rtl/ddr2_rd_user_fifo.sv
// rtl/ddr2_rd_user_fifo.sv - packs calibrated DDR2 read beats into user words with burst credit
module ddr2_rd_user_fifo
  import ddr2_rd_user_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH  = DDR2_DATA_WIDTH,
  parameter  int FIFO_DEPTH  = DDR2_USER_FIFO_DEPTH,
  parameter  int BURST_BEATS = DDR2_BURST_BEATS,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    comp_done,
  input  logic                    read_data_valid,
  input  logic [DATA_WIDTH-1:0]   read_data_fifo_rise,
  input  logic [DATA_WIDTH-1:0]   read_data_fifo_fall,
  input  logic                    ctrl_rd_issue,
  output logic                    rd_space_ok,
  output logic                    user_rd_valid,
  input  logic                    user_rd_ready,
  output logic [2*DATA_WIDTH-1:0] user_rd_data,
  output logic                    user_rd_last,
  output logic [CW-1:0]           fifo_count,
  output logic [1:0]              err
);

  localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  logic [BW-1:0]         r_beat_cnt;
  logic [CW-1:0]         r_reserved;
  logic                  r_space_ok;
  logic [1:0]            r_err;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_issue_ok;
  logic                  w_push_ok;
  logic                  w_overflow;
  logic                  w_space_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic [CW-1:0]         w_reserved_nxt;
  logic [2*DATA_WIDTH:0] w_rdata;

  assign w_push     = read_data_valid && comp_done;
  assign w_pop      = user_rd_valid && user_rd_ready;
  assign w_last     = (r_beat_cnt == BW'(BURST_BEATS - 1));
  assign w_issue_ok = ctrl_rd_issue && r_space_ok;

  ddr2_sync_fwft_fifo #(
    .WIDTH (2*DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wdata     ({w_last, read_data_fifo_fall, read_data_fifo_rise}),
    .o_valid     (user_rd_valid),
    .o_rdata     (w_rdata),
    .o_count     (fifo_count),
    .o_count_nxt (w_count_nxt),
    .o_push_ok   (w_push_ok),
    .o_overflow  (w_overflow)
  );

  // Recalibration drops all credit; already stored words still drain.
  always_comb begin
    w_reserved_nxt = r_reserved;
    if (!comp_done) begin
      w_reserved_nxt = '0;
    end else begin
      if (w_issue_ok) w_reserved_nxt = w_reserved_nxt + CW'(BURST_BEATS);
      if (w_push_ok && (r_reserved != '0)) w_reserved_nxt = w_reserved_nxt - CW'(1);
    end
  end

  assign w_space_nxt = comp_done && burst_fits(int'(w_count_nxt), int'(w_reserved_nxt),
                                               FIFO_DEPTH, BURST_BEATS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_cnt <= '0;
      r_reserved <= '0;
      r_space_ok <= 1'b0;
      r_err      <= '0;
    end else begin
      if (!comp_done)  r_beat_cnt <= '0;
      else if (w_push) r_beat_cnt <= w_last ? '0 : r_beat_cnt + BW'(1);
      r_reserved <= w_reserved_nxt;
      r_space_ok <= w_space_nxt;
      if (w_overflow)                  r_err[0] <= 1'b1;
      if (ctrl_rd_issue && !r_space_ok) r_err[1] <= 1'b1;
    end
  end

  assign rd_space_ok  = r_space_ok;
  assign user_rd_data = w_rdata[2*DATA_WIDTH-1:0];
  assign user_rd_last = w_rdata[2*DATA_WIDTH];
  assign err          = r_err;

endmodule

// File: tb/tb_ddr2_rd_user_fifo.sv
// tb/tb_ddr2_rd_user_fifo.sv - randomized self-checking bench for ddr2_rd_user_fifo
module tb_ddr2_rd_user_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int BB    = 2;

  logic          clk;
  logic          reset_n;
  logic          comp_done;
  logic          read_data_valid;
  logic [DW-1:0] rise;
  logic [DW-1:0] fall;
  logic          ctrl_rd_issue;
  logic          rd_space_ok;
  logic          user_rd_valid;
  logic          user_rd_ready;
  logic [2*DW-1:0] user_rd_data;
  logic          user_rd_last;
  logic [4:0]    fifo_count;
  logic [1:0]    err;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {last, fall, rise}, credit and sticky errors.
  logic [2*DW:0] m_q[$];
  int            m_beat;
  int            m_res;
  bit            m_space;
  logic [1:0]    m_err;

  ddr2_rd_user_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BURST_BEATS(BB)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .comp_done           (comp_done),
    .read_data_valid     (read_data_valid),
    .read_data_fifo_rise (rise),
    .read_data_fifo_fall (fall),
    .ctrl_rd_issue       (ctrl_rd_issue),
    .rd_space_ok         (rd_space_ok),
    .user_rd_valid       (user_rd_valid),
    .user_rd_ready       (user_rd_ready),
    .user_rd_data        (user_rd_data),
    .user_rd_last        (user_rd_last),
    .fifo_count          (fifo_count),
    .err                 (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_beat  = 0;
    m_res   = 0;
    m_space = 1'b0;
    m_err   = 2'b00;
  endtask

  // Advance one clock: the model consumes the inputs held across the edge.
  task automatic step();
    bit valid, pop, push, full, push_ok, issue_ok;
    int old_res;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      valid    = (m_q.size() != 0);
      pop      = valid && user_rd_ready;
      push     = read_data_valid && comp_done;
      full     = (m_q.size() == DEPTH);
      push_ok  = push && (!full || pop);
      issue_ok = ctrl_rd_issue && m_space;
      old_res  = m_res;
      if (push && full && !pop) m_err[0] = 1'b1;
      if (ctrl_rd_issue && !m_space) m_err[1] = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (push_ok) m_q.push_back({(m_beat == BB - 1), fall, rise});
      if (!comp_done) begin
        m_beat = 0;
        m_res  = 0;
      end else begin
        if (push) m_beat = (m_beat + 1) % BB;
        m_res = old_res + (issue_ok ? BB : 0) - ((push_ok && old_res > 0) ? 1 : 0);
      end
      m_space = comp_done && ((DEPTH - m_q.size() - m_res) >= BB);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    read_data_valid = 1'b0;
    ctrl_rd_issue   = 1'b0;
    rise            = '0;
    fall            = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; comp_done = 1'b0; user_rd_ready = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) step();
    checks++; if ({user_rd_valid, user_rd_last, fifo_count, err, rd_space_ok} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0", {user_rd_valid, user_rd_last, fifo_count, err, rd_space_ok});
    end
    checks++; if (user_rd_data !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", user_rd_data);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    comp_done = 1'b1;
    step();
    checks++; if (rd_space_ok !== 1'b1) begin
      errors++; $display("FAIL basic_space: got %b expected 1", rd_space_ok);
    end
    ctrl_rd_issue = 1'b1;
    step();
    ctrl_rd_issue = 1'b0; user_rd_ready = 1'b1;
    read_data_valid = 1'b1; rise = 32'h11111111; fall = 32'h22222222;
    step();
    checks++; if ({user_rd_valid, user_rd_last, user_rd_data} !== {2'b10, 64'h2222222211111111}) begin
      errors++; $display("FAIL basic_word0: got v=%b l=%b d=%h expected v=1 l=0 d=2222222211111111", user_rd_valid, user_rd_last, user_rd_data);
    end
    rise = 32'h33333333; fall = 32'h44444444;
    step();
    checks++; if ({user_rd_valid, user_rd_last, user_rd_data} !== {2'b11, 64'h4444444433333333}) begin
      errors++; $display("FAIL basic_word1: got v=%b l=%b d=%h expected v=1 l=1 d=4444444433333333", user_rd_valid, user_rd_last, user_rd_data);
    end
    idle_inputs();
    step();
    checks++; if (user_rd_valid !== 1'b0 || fifo_count !== 5'd0) begin
      errors++; $display("FAIL basic_empty: got v=%b cnt=%0d expected v=0 cnt=0", user_rd_valid, fifo_count);
    end
  endtask

  task automatic test_calib_drop();
    comp_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_data_valid = 1'b1; rise = $urandom; fall = $urandom;
      step();
      checks++; if ({user_rd_valid, fifo_count, err} !== 8'b0) begin
        errors++; $display("FAIL calib_drop[%0d]: got v=%b cnt=%0d err=%b expected all 0", i, user_rd_valid, fifo_count, err);
      end
    end
    idle_inputs();
    comp_done = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [2*DW-1:0] exp_d [DEPTH];
    user_rd_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      ctrl_rd_issue = 1'b1;
      step();
      checks++; if (rd_space_ok !== (i < 8)) begin
        errors++; $display("FAIL fill_space[%0d]: got %b expected %b", i, rd_space_ok, (i < 8));
      end
    end
    step();
    ctrl_rd_issue = 1'b0;
    checks++; if (err !== 2'b10) begin
      errors++; $display("FAIL fill_issue_err: got %b expected 10", err);
    end
    for (int i = 0; i < DEPTH; i++) begin
      read_data_valid = 1'b1; rise = $urandom; fall = $urandom;
      exp_d[i] = {fall, rise};
      step();
    end
    idle_inputs();
    checks++; if (fifo_count !== 5'd16 || err !== 2'b10) begin
      errors++; $display("FAIL fill_full: got cnt=%0d err=%b expected cnt=16 err=10", fifo_count, err);
    end
    user_rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if ({user_rd_valid, user_rd_last, user_rd_data} !== {1'b1, (i % 2 == 1), exp_d[i]}) begin
        errors++; $display("FAIL fill_drain[%0d]: got v=%b l=%b d=%h expected v=1 l=%b d=%h", i, user_rd_valid, user_rd_last, user_rd_data, (i % 2 == 1), exp_d[i]);
      end
      step();
    end
    checks++; if (user_rd_valid !== 1'b0 || rd_space_ok !== 1'b1) begin
      errors++; $display("FAIL fill_after: got v=%b space=%b expected v=0 space=1", user_rd_valid, rd_space_ok);
    end
  endtask

  task automatic test_full();
    user_rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      read_data_valid = 1'b1; rise = $urandom; fall = $urandom;
      step();
    end
    checks++; if (fifo_count !== 5'd16) begin
      errors++; $display("FAIL full_count: got %0d expected 16", fifo_count);
    end
    user_rd_ready = 1'b1; rise = $urandom; fall = $urandom;
    step();
    checks++; if (fifo_count !== 5'd16 || err[0] !== 1'b0 || user_rd_data !== m_q[0][2*DW-1:0]) begin
      errors++; $display("FAIL full_pushpop: got cnt=%0d err0=%b d=%h expected cnt=16 err0=0 d=%h", fifo_count, err[0], user_rd_data, m_q[0][2*DW-1:0]);
    end
    user_rd_ready = 1'b0; rise = $urandom; fall = $urandom;
    step();
    checks++; if (fifo_count !== 5'd16 || err[0] !== 1'b1 || user_rd_data !== m_q[0][2*DW-1:0]) begin
      errors++; $display("FAIL full_overflow: got cnt=%0d err0=%b d=%h expected cnt=16 err0=1 d=%h", fifo_count, err[0], user_rd_data, m_q[0][2*DW-1:0]);
    end
    idle_inputs();
    user_rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if ({user_rd_valid, user_rd_last, user_rd_data} !== {1'b1, m_q[0]}) begin
        errors++; $display("FAIL full_drain[%0d]: got l=%b d=%h expected l=%b d=%h", i, user_rd_last, user_rd_data, m_q[0][2*DW], m_q[0][2*DW-1:0]);
      end
      step();
    end
  endtask

  task automatic test_random();
    int issued = 0, pending = 0, cyc = 0;
    bit hold = 1'b0;
    logic [2*DW:0] held;
    while ((issued < 100 || pending > 0 || m_q.size() > 0) && cyc < 5000) begin
      checks++; if ({user_rd_valid, fifo_count, rd_space_ok, err} !== {(m_q.size() != 0), 5'(m_q.size()), m_space, m_err}) begin
        errors++; $display("FAIL rand_status@%0d: got v=%b cnt=%0d sp=%b err=%b expected v=%b cnt=%0d sp=%b err=%b", cyc, user_rd_valid, fifo_count, rd_space_ok, err, (m_q.size() != 0), m_q.size(), m_space, m_err);
      end
      if (m_q.size() != 0) begin
        checks++; if ({user_rd_last, user_rd_data} !== m_q[0]) begin
          errors++; $display("FAIL rand_data@%0d: got %h expected %h", cyc, {user_rd_last, user_rd_data}, m_q[0]);
        end
      end
      if (hold) begin
        checks++; if ({user_rd_last, user_rd_data} !== held) begin
          errors++; $display("FAIL rand_stable@%0d: got %h expected %h", cyc, {user_rd_last, user_rd_data}, held);
        end
      end
      user_rd_ready = ($urandom_range(0, 2) != 0);
      ctrl_rd_issue = (issued < 100) && m_space && ($urandom_range(0, 1) == 1);
      read_data_valid = (pending > 0) && ($urandom_range(0, 3) != 0);
      rise = $urandom; fall = $urandom;
      if (read_data_valid) pending--;
      if (ctrl_rd_issue) begin
        issued++;
        pending += BB;
      end
      hold = user_rd_valid && !user_rd_ready;
      held = {user_rd_last, user_rd_data};
      step();
      cyc++;
    end
    idle_inputs();
    checks++; if (cyc >= 5000) begin
      errors++; $display("FAIL rand_timeout: got %0d cycles expected under 5000", cyc);
    end
  endtask

  task automatic test_reset_mid();
    user_rd_ready = 1'b0;
    ctrl_rd_issue = 1'b1;
    repeat (4) step();
    ctrl_rd_issue = 1'b0;
    for (int i = 0; i < 5; i++) begin
      read_data_valid = 1'b1; rise = $urandom; fall = $urandom;
      step();
    end
    idle_inputs();
    checks++; if (fifo_count !== 5'd5 || m_res != 3) begin
      errors++; $display("FAIL mid_setup: got cnt=%0d res=%0d expected cnt=5 res=3", fifo_count, m_res);
    end
    reset_n = 1'b0;
    #1;
    checks++; if ({user_rd_valid, user_rd_last, fifo_count, err, rd_space_ok} !== 10'b0 || user_rd_data !== 64'h0) begin
      errors++; $display("FAIL mid_reset: got v=%b l=%b cnt=%0d err=%b sp=%b d=%h expected all 0", user_rd_valid, user_rd_last, fifo_count, err, rd_space_ok, user_rd_data);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++; if (fifo_count !== 5'd0 || rd_space_ok !== 1'b1 || user_rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release: got cnt=%0d sp=%b v=%b expected cnt=0 sp=1 v=0", fifo_count, rd_space_ok, user_rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_calib_drop();
    test_fill();
    test_full();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
